// File: rtl/c7bicu_if.sv
// rtl/c7bicu_if.sv - AXI-style read channel bundle between the fetch interface and memory
interface c7bicu_if #(
  parameter int ID_W = 4
) ();
  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [ID_W-1:0] arid;
  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;

  // Fetch unit side: issues the read address, accepts read data
  modport master (
    output arvalid, araddr, arlen, arsize, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  // Memory side
  modport slave (
    input  arvalid, araddr, arlen, arsize, arid, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/c7bicu.sv
// rtl/c7bicu.sv - instruction fetch memory interface: one 64-bit fetch as a 2-beat 32-bit read burst
module c7bicu #(
  parameter int ID_W     = 4,
  parameter int FETCH_ID = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] ifu_icu_addr_ic1,
  input  logic        ifu_icu_req_ic1,
  output logic        icu_ifu_ack_ic1,
  input  logic        ifu_icu_cancel,
  output logic        icu_ifu_data_valid_ic2,
  output logic [63:0] icu_ifu_data_ic2,
  output logic        icu_ifu_err_ic2,
  c7bicu_if.master    mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R0   = 2'd2,
    R1   = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] araddr_q;
  logic [31:0] beat0_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        err_acc_q;
  logic        drop_q;
  logic        data_valid_q;
  logic [63:0] data_q;
  logic        err_q;

  // Next values of the drop flag and the accumulated error when a beat/cancel lands this cycle
  logic drop_d;
  logic err_d;
  logic unused_bits;

  assign drop_d = drop_q | ifu_icu_cancel;
  assign err_d  = err_acc_q | (mem.rresp != 2'b00);

  // Low address bits are ignored and rlast is informational; beats are counted by the FSM
  assign unused_bits = ^{ifu_icu_addr_ic1[2:0], mem.rlast};

  // A request is taken only while idle, including the cycle that returns the previous fetch
  assign icu_ifu_ack_ic1 = ifu_icu_req_ic1 && (state_q == IDLE);

  assign mem.arvalid = arvalid_q;
  assign mem.araddr  = araddr_q;
  assign mem.arlen   = 8'd1;
  assign mem.arsize  = 3'b010;
  assign mem.arid    = ID_W'(FETCH_ID);
  assign mem.rready  = rready_q;

  assign icu_ifu_data_valid_ic2 = data_valid_q;
  assign icu_ifu_data_ic2       = data_q;
  assign icu_ifu_err_ic2        = err_q;

  // Fetch FSM: address phase, two counted data beats, then a one-cycle result pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      araddr_q     <= 32'd0;
      beat0_q      <= 32'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      err_acc_q    <= 1'b0;
      drop_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= 64'd0;
      err_q        <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Cancel is meaningless here: nothing is in flight, and a same-cycle request is kept
          if (icu_ifu_ack_ic1) begin
            araddr_q  <= {ifu_icu_addr_ic1[31:3], 3'b000};
            err_acc_q <= 1'b0;
            drop_q    <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= AR;
          end
        end
        AR: begin
          // arvalid is never withdrawn once raised, even if the fetch is cancelled
          drop_q <= drop_d;
          if (mem.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= R0;
          end
        end
        R0: begin
          drop_q <= drop_d;
          if (mem.rvalid) begin
            beat0_q   <= mem.rdata;
            err_acc_q <= err_d;
            state_q   <= R1;
          end
        end
        R1: begin
          drop_q <= drop_d;
          if (mem.rvalid) begin
            rready_q  <= 1'b0;
            err_acc_q <= err_d;
            drop_q    <= 1'b0;
            state_q   <= IDLE;
            // A cancel arriving with the final beat still suppresses the result
            if (!drop_d) begin
              data_valid_q <= 1'b1;
              data_q       <= {mem.rdata, beat0_q};
              err_q        <= err_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c7bicu.sv
// tb/tb_c7bicu.sv - self-checking bench for c7bicu with a memory responder and fetch-level model
module tb_c7bicu;

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic        req;
  logic        ack;
  logic        cancel;
  logic        dv;
  logic [63:0] data;
  logic        err;

  c7bicu_if #(.ID_W(4)) bus ();

  c7bicu #(.ID_W(4), .FETCH_ID(0)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .ifu_icu_addr_ic1       (addr),
    .ifu_icu_req_ic1        (req),
    .icu_ifu_ack_ic1        (ack),
    .ifu_icu_cancel         (cancel),
    .icu_ifu_data_valid_ic2 (dv),
    .icu_ifu_data_ic2       (data),
    .icu_ifu_err_ic2        (err),
    .mem                    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: explicit words where preloaded, otherwise a fixed hash of the address
  logic [31:0] mem_words [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Per-fetch memory behaviour, sampled at acceptance of the request
  int cfg_arw = 0;
  int cfg_gap = 0;
  bit cfg_e0  = 0;
  bit cfg_e1  = 0;

  // Fetch-level reference model state
  int          tick = 0;
  bit          outstanding, ar_done, dropped, acc_err;
  int          beat, ar_wait_cnt, gap_cnt, cur_arw, cur_gap;
  bit          cur_e0, cur_e1;
  logic [31:0] cur_addr, b0;
  bit          exp_dv, exp_err, exp_arvalid, exp_rready;
  logic [63:0] exp_data;
  int          done_cnt = 0, dv_cnt = 0, last_dv_tick = 0, last_ack_tick = 0;
  logic [63:0] last_dv_data;
  logic        last_dv_err;

  // Memory responder plus model: checks what the last edge produced, then plans the next edge
  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    forever begin
      bit ar_hs, r_hs, ack_exp;
      @(negedge clk);
      #2;
      tick++;
      if (!resetn) begin
        outstanding = 0; ar_done = 0; dropped = 0; beat = 0;
        exp_dv = 0; exp_arvalid = 0; exp_rready = 0;
        bus.arready = 1'b0; bus.rvalid = 1'b0;
        continue;
      end
      chk("data_valid", dv, exp_dv);
      if (exp_dv) begin
        chk("data", data, exp_data);
        chk("err", err, exp_err);
        dv_cnt++;
        last_dv_tick = tick;
        last_dv_data = data;
        last_dv_err  = err;
      end
      chk("arvalid", bus.arvalid, exp_arvalid);
      chk("rready", bus.rready, exp_rready);
      if (bus.arvalid) begin
        chk("araddr", bus.araddr, cur_addr);
        chk("arlen", bus.arlen, 8'd1);
        chk("arsize", bus.arsize, 3'b010);
        chk("arid", bus.arid, 4'd0);
      end
      ack_exp = req && !outstanding;
      if (req) chk("ack", ack, ack_exp);

      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = $urandom;
      bus.rresp   = 2'($urandom_range(0, 3));
      bus.rlast   = 1'b0;
      if (bus.arvalid && !ar_done) begin
        if (ar_wait_cnt >= cur_arw) bus.arready = 1'b1;
        else ar_wait_cnt++;
      end else if (ar_done && beat < 2) begin
        if (gap_cnt >= cur_gap) begin
          bus.rvalid = 1'b1;
          bus.rdata  = mem_word(cur_addr + 32'(4 * beat));
          bus.rresp  = ((beat == 0) ? cur_e0 : cur_e1) ? 2'b10 : 2'b00;
          bus.rlast  = (beat == 1);
        end else gap_cnt++;
      end

      ar_hs  = bus.arvalid && bus.arready;
      r_hs   = bus.rvalid && bus.rready;
      exp_dv = 0;
      if (cancel && outstanding) dropped = 1;
      if (r_hs) begin
        if (beat == 0) b0 = bus.rdata;
        acc_err = acc_err | (bus.rresp != 2'b00);
        beat++;
        gap_cnt = 0;
        if (beat == 2) begin
          outstanding = 0;
          done_cnt++;
          if (!dropped) begin
            exp_dv   = 1;
            exp_data = {bus.rdata, b0};
            exp_err  = acc_err;
          end
        end
      end
      if (ar_hs) ar_done = 1;
      if (ack_exp) begin
        outstanding = 1; ar_done = 0; dropped = 0; acc_err = 0; beat = 0;
        cur_addr = {addr[31:3], 3'b000};
        cur_arw = cfg_arw; cur_gap = cfg_gap; cur_e0 = cfg_e0; cur_e1 = cfg_e1;
        ar_wait_cnt = 0; gap_cnt = 0;
        last_ack_tick = tick;
      end
      exp_arvalid = outstanding && !ar_done;
      exp_rready  = outstanding && ar_done;
    end
  end

  // One fetch: raise req until accepted, assert cancel on the chosen cycle after acceptance
  // (0 = together with the request), then wait for the final beat plus the result cycle
  task automatic do_fetch(input logic [31:0] a, input int arw, input int gap,
                          input bit e0, input bit e1, input int cancel_at);
    int start_done, cyc, post, n;
    cfg_arw = arw; cfg_gap = gap; cfg_e0 = e0; cfg_e1 = e1;
    start_done = done_cnt;
    @(negedge clk);
    addr = a; req = 1'b1; cancel = (cancel_at == 0);
    #1;
    n = 0;
    while (!ack && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 50 cycles");
    end
    cyc = 0; post = 0;
    while (post < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req = 1'b0;
      cancel = (cyc == cancel_at);
      if (done_cnt != start_done) post++;
    end
    cancel = 1'b0;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL fetch_timeout: got no completion expected completion within 200 cycles");
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] w0, w1;
    int          arw, gap;
    bit          e0, e1;
    int          cancel_at;
    bit          exp_valid;
    logic [63:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int dv0;
    int k;
    resetn = 1'b0; req = 1'b0; cancel = 1'b0; addr = 32'd0;

    vecs[0]  = '{32'h1C00_0004, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, 0, -1, 1, 64'h2222_2222_1111_1111, 0};
    vecs[1]  = '{32'h1C00_0040, 32'hAAAA_0001, 32'hAAAA_0002, 3, 2, 0, 0, -1, 1, 64'hAAAA_0002_AAAA_0001, 0};
    vecs[2]  = '{32'h1C00_0008, 32'h3333_3333, 32'h4444_4444, 0, 0, 0, 0,  2, 0, 64'h0, 0};
    vecs[3]  = '{32'h1C00_1000, 32'h5555_5555, 32'h6666_6666, 0, 0, 0, 0, -1, 1, 64'h6666_6666_5555_5555, 0};
    vecs[4]  = '{32'h1C00_0100, 32'h7777_7777, 32'h8888_8888, 0, 0, 1, 0, -1, 1, 64'h8888_8888_7777_7777, 1};
    vecs[5]  = '{32'h1C00_0108, 32'h9999_9999, 32'h1234_5678, 0, 0, 0, 0, -1, 1, 64'h1234_5678_9999_9999, 0};
    vecs[6]  = '{32'h1C00_0110, 32'hCAFE_0000, 32'hBEEF_0001, 1, 1, 0, 1, -1, 1, 64'hBEEF_0001_CAFE_0000, 1};
    vecs[7]  = '{32'h1C00_0118, 32'h0BAD_0001, 32'h0BAD_0002, 2, 0, 0, 0,  1, 0, 64'h0, 0};
    vecs[8]  = '{32'h1C00_0120, 32'h0BAD_0003, 32'h0BAD_0004, 0, 0, 0, 0,  3, 0, 64'h0, 0};
    vecs[9]  = '{32'h1C00_012F, 32'hD00D_0001, 32'hD00D_0002, 0, 0, 0, 0,  4, 1, 64'hD00D_0002_D00D_0001, 0};
    vecs[10] = '{32'h1C00_0130, 32'hFEED_0001, 32'hFEED_0002, 0, 0, 0, 0,  0, 1, 64'hFEED_0002_FEED_0001, 0};
    vecs[11] = '{32'h1C00_0138, 32'h0BAD_0005, 32'h0BAD_0006, 0, 1, 0, 0,  5, 0, 64'h0, 0};
    foreach (vecs[i]) begin
      mem_words[{vecs[i].a[31:3], 3'b000}]       = vecs[i].w0;
      mem_words[{vecs[i].a[31:3], 3'b000} + 32'd4] = vecs[i].w1;
    end

    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_dv", dv, 0);
    chk("rst_data", data, 0);
    chk("rst_err", err, 0);
    chk("rst_araddr", bus.araddr, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      dv0 = dv_cnt;
      do_fetch(vecs[i].a, vecs[i].arw, vecs[i].gap, vecs[i].e0, vecs[i].e1, vecs[i].cancel_at);
      chk($sformatf("vec%0d_valid_count", i), 64'(dv_cnt - dv0), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), last_dv_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_err", i), last_dv_err, vecs[i].exp_err);
        chk($sformatf("vec%0d_latency", i), 64'(last_dv_tick - last_ack_tick),
            64'(4 + vecs[i].arw + 2 * vecs[i].gap));
      end
    end

    // Continuous requests: each new request is accepted in the cycle the previous result returns
    cfg_arw = 0; cfg_gap = 0; cfg_e0 = 0; cfg_e1 = 0;
    dv0 = dv_cnt; k = 0;
    @(negedge clk);
    req = 1'b1; addr = 32'h1C00_0000;
    for (int c = 0; c < 40 && k < 3; c++) begin
      #1;
      if (ack) begin
        k++;
        if (k > 1) chk($sformatf("b2b_ack%0d_with_dv", k), dv, 1);
        @(negedge clk);
        addr = 32'h1C00_0000 + 32'(8 * k);
      end else @(negedge clk);
    end
    req = 1'b0;
    chk("b2b_acks", 64'(k), 64'd3);
    repeat (8) @(negedge clk);
    chk("b2b_dv_count", 64'(dv_cnt - dv0), 64'd3);
    chk("b2b_last_data", last_dv_data, {mem_word(32'h1C00_0014), mem_word(32'h1C00_0010)});

    // Reset asserted while the fetch waits in the first data beat
    cfg_arw = 0; cfg_gap = 3;
    @(negedge clk);
    req = 1'b1; addr = 32'h1C00_0200;
    #1;
    chk("rstseq_ack", ack, 1);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #4;
    chk("rstseq_rready_before", bus.rready, 1);
    resetn = 1'b0;
    #1;
    chk("rstseq_arvalid", bus.arvalid, 0);
    chk("rstseq_rready", bus.rready, 0);
    chk("rstseq_dv", dv, 0);
    chk("rstseq_data", data, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cfg_gap = 0;
    dv0 = dv_cnt;
    @(negedge clk);
    req = 1'b1; addr = 32'h1C00_0300;
    #1;
    chk("rstseq_first_ack", ack, 1);
    @(negedge clk);
    req = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstseq_dv_count", 64'(dv_cnt - dv0), 64'd1);
    chk("rstseq_data_after", last_dv_data, {mem_word(32'h1C00_0304), mem_word(32'h1C00_0300)});

    // Randomized fetches; the model checks every cycle
    for (int i = 0; i < 40; i++) begin
      int ca;
      ca = $urandom_range(0, 9);
      do_fetch(32'h1C00_0000 | 32'($urandom_range(0, 4095) << 3) | 32'($urandom_range(0, 7)),
               $urandom_range(0, 3), $urandom_range(0, 2),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               (ca > 6) ? -1 : ca);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000 time units");
    $fatal(1);
  end

endmodule
